pwm_capture: RTL
================

# pwm_capture

Servo PWM decoder: measures the high time of an incoming servo pulse train on `pwm_in` and converts it back to the 9-bit angle code (0–270 degrees) used by the PWM generator. It is the receive end of the servo PWM link: it closes the loop on our own generator output, or reads an external servo/RC source. It also reports out-of-range pulses and loss of signal. Default constants assume `sclk` = 50 MHz, a 20 ms frame, and a 0.5–2.5 ms pulse span.

## Interface
- `MIN_CNT`, 25000: pulse width in `sclk` cycles that maps to angle 0 (0.5 ms).
- `MAX_CNT`, 125000: largest accepted pulse width (2.5 ms).
- `STEP`, 370: `sclk` cycles per degree.
- `MAX_ANG`, 270: angle clamp value.
- `TIMEOUT`, 1500000: cycles without a rising edge before declaring signal lost (30 ms).
- `CNT_W`, 21: width of the width and timeout counters.

Ports:
- `sclk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pwm_in`  in  1  asynchronous servo PWM input.
- `angle`  out  9  last decoded angle, 0..270.
- `angle_valid`  out  1  one-cycle strobe when `angle` is updated.
- `pulse_err`  out  1  one-cycle strobe when a pulse width is outside [MIN_CNT, MAX_CNT].
- `sig_lost`  out  1  level; high while no rising edge has been seen for TIMEOUT cycles.

## Operation
- **Input conditioning.** `pwm_in` passes through a 2-flop synchronizer (`s1`, `s2`) plus a delayed copy `s3`.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
  - An edge on `pwm_in` sampled at clock k is detected at clock k+2.
- **State machine:** WAIT_RISE, HIGH, CALC, DONE.
  - **WAIT_RISE.** On rise: set `wcnt` = 1 and go to HIGH. A level that is already high at reset release is never measured; the FSM waits for a true rise.
  - **HIGH.** `wcnt` increments each cycle while `s2` is high, saturating at all-ones. On fall, W = `wcnt`:
    - If W < MIN_CNT or W > MAX_CNT: pulse `pulse_err` and go to WAIT_RISE.
    - Otherwise: load `rem` = W − MIN_CNT and `q` = 0, and go to CALC.
  - **CALC.** Iterative subtractive divide, one step per cycle.
    - If `rem` >= STEP and `q` < MAX_ANG: `rem` −= STEP, `q` += 1.
    - Otherwise go to DONE.
    - The result is floor((W − MIN_CNT)/STEP), clamped to MAX_ANG.
  - **DONE.** `angle` <= `q`, `angle_valid` = 1 for this cycle, then go to WAIT_RISE.
- **Edges during CALC/DONE** are ignored. That pulse is lost with no output and no error. At nominal rates this cannot occur, since CALC is at most 271 cycles and the frame is 20 ms.
- **Timeout counter `tcnt`.**
  - Clears on every rise; otherwise increments, saturating at TIMEOUT.
  - When `tcnt` reaches TIMEOUT: `sig_lost` = 1, and if the FSM is in HIGH it aborts to WAIT_RISE with no `pulse_err` (line stuck high).
  - `sig_lost` clears in the cycle after the next rise.
- **Error isolation.** `angle` changes only in DONE; errors and timeouts never alter it.
- **Arithmetic.** All compares are unsigned at CNT_W bits; `q` is 9 bits.

## Timing
- **Reset** (`rst_n` low at a clock edge): `angle` = 135, `angle_valid` = 0, `pulse_err` = 0, `sig_lost` = 1, state = WAIT_RISE, all counters = 0, synchronizer flops = 0.
- **Reset mid-pulse:** all state is discarded. The next pulse is measured only after a fresh rise.
- **Width definition:** W equals the number of `sclk` cycles `pwm_in` is sampled high, ±1 for metastability.
- **Latency.** Falling edge on `pwm_in` sampled at clock k:
  - fall detected at k+2;
  - CALC occupies k+3 .. k+3+q;
  - DONE (`angle_valid` high, `angle` updated) at k+4+q;
  - `pulse_err` is high at k+2.
- **Strobes.** `angle_valid` and `pulse_err` are each exactly one cycle wide and never assert in the same cycle.
- **Throughput.** One result per pulse; the minimum frame is MAX_CNT + 280 cycles.

## Test plan
- **Nominal decode.** Reset, then pulses with W = 25000, 75000, 125000 at a 1,000,000-cycle period -> `angle` = 0, 135, 270. Each `angle_valid` fires exactly once, q+4 cycles after the falling edge.
- **Clamp and rounding.** W = 25369 -> 0; W = 25370 -> 1; W = 124900 -> 270.
- **Out of range.** W = 24999 and W = 125001 -> a `pulse_err` pulse per pulse; `angle` holds its previous value; no `angle_valid`.
- **Signal loss.**
  - `pwm_in` held low for 1,500,000 cycles after a valid pulse -> `sig_lost` rises and `angle` holds.
  - Next valid pulse -> `sig_lost` falls and the pulse decodes normally.
  - `pwm_in` stuck high -> `sig_lost` = 1, no `pulse_err`, no `angle_valid`.
- **Reset.**
  - Release `rst_n` while `pwm_in` is high -> first falling edge ignored; `angle` = 135 until the next full pulse.
  - Assert `rst_n` low mid-pulse -> outputs return to reset values.
- **Back-to-back.** Rise 100 cycles after the fall of a W = 125000 pulse (during CALC) -> that second pulse produces no output; the following pulse decodes.

Source files
------------

// File: rtl/pwm_capture.sv
// Servo PWM decoder: measures pulse high time and converts it to a 0..MAX_ANG
// angle code; flags out-of-range pulses and loss of signal.
module pwm_capture #(
    parameter int MIN_CNT = 25000,
    parameter int MAX_CNT = 125000,
    parameter int STEP    = 370,
    parameter int MAX_ANG = 270,
    parameter int TIMEOUT = 1500000,
    parameter int CNT_W   = 21
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [8:0] angle,
    output logic       angle_valid,
    output logic       pulse_err,
    output logic       sig_lost
);

    localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] L_STEP = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] L_TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
    localparam logic [8:0]       L_MAXA = 9'(MAX_ANG);

    typedef enum logic [1:0] {WAIT_RISE, HIGH, CALC, DONE} state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_fill;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] r_rem;
    logic [8:0]       r_q;
    logic [8:0]       r_angle;
    logic             r_valid;
    logic             r_err;
    logic             r_lost;

    logic w_live;
    logic w_rise;
    logic w_fall;
    logic w_tmo;

    // A rise only counts once s3 holds a real post-reset sample, so a line
    // already high at reset release is never mistaken for a fresh edge.
    assign w_live = (r_fill == 2'd3);
    assign w_rise = w_live & r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_tmo  = (r_tcnt == L_TMO);

    assign angle       = r_angle;
    assign angle_valid = r_valid;
    assign pulse_err   = r_err;
    assign sig_lost    = r_lost;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state <= WAIT_RISE;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_fill  <= 2'd0;
            r_wcnt  <= '0;
            r_tcnt  <= '0;
            r_rem   <= '0;
            r_q     <= 9'd0;
            r_angle <= 9'd135;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_lost  <= 1'b1;
        end else begin
            r_s1    <= pwm_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (!w_live) begin
                r_fill <= r_fill + 2'd1;
            end

            if (w_rise) begin
                r_tcnt <= '0;
                r_lost <= 1'b0;
            end else if (w_tmo) begin
                r_lost <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + L_ONE;
            end

            unique case (r_state)
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_wcnt  <= L_ONE;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    // A line stuck high aborts silently, no pulse_err.
                    if (w_tmo) begin
                        r_state <= WAIT_RISE;
                    end else if (w_fall) begin
                        if (r_wcnt < L_MIN || r_wcnt > L_MAX) begin
                            r_err   <= 1'b1;
                            r_state <= WAIT_RISE;
                        end else begin
                            r_rem   <= r_wcnt - L_MIN;
                            r_q     <= 9'd0;
                            r_state <= CALC;
                        end
                    end else if (r_s2 && r_wcnt != '1) begin
                        r_wcnt <= r_wcnt + L_ONE;
                    end
                end
                CALC: begin
                    if (r_rem >= L_STEP && r_q < L_MAXA) begin
                        r_rem <= r_rem - L_STEP;
                        r_q   <= r_q + 9'd1;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_angle <= r_q;
                    r_valid <= 1'b1;
                    r_state <= WAIT_RISE;
                end
            endcase
        end
    end

endmodule
